// File: rtl/pipe_stall_ctrl.sv
// Pipeline stall/flush controller: load-use interlock, branch flush, multi-cycle
// MDU hold and data-memory backpressure, plus a saturating frozen-PC counter.
module pipe_stall_ctrl #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  input  logic [4:0]       ex_rd,
  input  logic             ex_is_load,
  input  logic             ex_is_mdu,
  input  logic             ex_br_taken,
  input  logic             mdu_done,
  input  logic             mem_req,
  input  logic             mem_ready,
  input  logic             cnt_clr,
  output logic             en_pc,
  output logic             en_ifid,
  output logic             en_idex,
  output logic             en_exmem,
  output logic             en_memwb,
  output logic             flush_ifid,
  output logic             flush_idex,
  output logic             flush_exmem,
  output logic             mdu_start,
  output logic [CNT_W-1:0] stall_cnt
);

  typedef enum logic {RUN = 1'b0, MDU_WAIT = 1'b1} state_t;

  state_t            state_q, state_d;
  logic              done_pend_q, done_pend_d;
  logic [CNT_W-1:0]  cnt_q;
  logic              mem_stall;
  logic              load_use;

  assign mem_stall = mem_req & ~mem_ready;
  assign load_use  = ex_is_load & (ex_rd != 5'd0) &
                     ((id_use_rs1 & (id_rs1 == ex_rd)) | (id_use_rs2 & (id_rs2 == ex_rd)));

  always_comb begin
    state_d     = state_q;
    done_pend_d = done_pend_q;
    en_pc       = 1'b0;
    en_ifid     = 1'b0;
    en_idex     = 1'b0;
    en_exmem    = 1'b0;
    en_memwb    = 1'b0;
    flush_ifid  = 1'b0;
    flush_idex  = 1'b0;
    flush_exmem = 1'b0;
    mdu_start   = 1'b0;
    if (reset) begin
      state_d     = RUN;
      done_pend_d = 1'b0;
    end else if (mem_stall) begin
      if (mdu_done) done_pend_d = 1'b1;
    end else begin
      case (state_q)
        RUN: begin
          if (ex_br_taken) begin
            {en_pc, en_ifid, en_idex, en_exmem, en_memwb} = 5'b11111;
            flush_ifid = 1'b1;
            flush_idex = 1'b1;
          end else if (ex_is_mdu) begin
            mdu_start   = 1'b1;
            en_exmem    = 1'b1;
            flush_exmem = 1'b1;
            en_memwb    = 1'b1;
            // a done captured outside a wait is stale; never let it end this one
            done_pend_d = 1'b0;
            state_d     = MDU_WAIT;
          end else if (load_use) begin
            en_idex    = 1'b1;
            flush_idex = 1'b1;
            en_exmem   = 1'b1;
            en_memwb   = 1'b1;
          end else begin
            {en_pc, en_ifid, en_idex, en_exmem, en_memwb} = 5'b11111;
          end
        end
        MDU_WAIT: begin
          if (mdu_done | done_pend_q) begin
            {en_pc, en_ifid, en_idex, en_exmem, en_memwb} = 5'b11111;
            done_pend_d = 1'b0;
            state_d     = RUN;
          end else begin
            en_exmem    = 1'b1;
            flush_exmem = 1'b1;
            en_memwb    = 1'b1;
          end
        end
        default: state_d = RUN;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= RUN;
      done_pend_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      done_pend_q <= done_pend_d;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (cnt_clr) begin
      cnt_q <= '0;
    end else if (!en_pc && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_q <= cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  assign stall_cnt = cnt_q;

endmodule
